// File: rtl/wait_state_memory.sv
// Word-addressed synchronous RAM with programmable wait states, a registered
// one-cycle resp pulse and an error flag for out-of-range or illegal requests.
module wait_state_memory #(
  parameter int    DATA_WIDTH = 8,
  parameter int    DEPTH      = 8,
  parameter int    ADDR_WIDTH = 8,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = "memory.lst"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_q;
  logic                  wr_q;

  logic                  in_range;
  logic                  illegal;
  logic                  finishing;
  logic                  commit_write;
  logic                  commit_read;
  logic [IDX_W-1:0]      idx;

  assign in_range     = 32'(addr_q) < 32'(DEPTH);
  assign idx          = addr_q[IDX_W-1:0];
  assign illegal      = rd_q & wr_q;
  assign finishing    = (state == WAIT) && (count == 4'd0);
  assign commit_write = finishing && wr_q && !rd_q && in_range;
  assign commit_read  = finishing && rd_q && !wr_q && in_range;

  // The counter starts at LATENCY so resp lands at acceptance + LATENCY + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read || write) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            rd_q    <= read;
            wr_q    <= write;
            count   <= 4'(LATENCY);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= RESP;
            resp  <= 1'b1;
            err   <= illegal || !in_range;
            if (commit_read) begin
              rdata <= mem[idx];
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          resp  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset so it stays inferable as RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit_write) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory: timing, data, error and reset scenarios,
// plus a latency sweep on three extra instances.
module tb_wait_state_memory;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       resp;
  logic [7:0] rdata;
  logic       err;
  logic       busy;

  logic       s_read;
  logic       s_write;
  logic [7:0] s_addr;
  logic [7:0] s_wdata;
  logic       s_resp  [3];
  logic [7:0] s_rdata [3];
  logic       s_err   [3];
  logic       s_busy  [3];

  int checks = 0;
  int errors = 0;

  wait_state_memory #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(8), .LATENCY(2), .INIT_FILE("")) u_dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .resp(resp), .rdata(rdata), .err(err), .busy(busy));

  wait_state_memory #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(8), .LATENCY(0), .INIT_FILE("")) u_l0 (
    .clk(clk), .rst_n(rst_n), .read(s_read), .write(s_write), .addr(s_addr), .wdata(s_wdata),
    .resp(s_resp[0]), .rdata(s_rdata[0]), .err(s_err[0]), .busy(s_busy[0]));

  wait_state_memory #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(8), .LATENCY(1), .INIT_FILE("")) u_l1 (
    .clk(clk), .rst_n(rst_n), .read(s_read), .write(s_write), .addr(s_addr), .wdata(s_wdata),
    .resp(s_resp[1]), .rdata(s_rdata[1]), .err(s_err[1]), .busy(s_busy[1]));

  wait_state_memory #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(8), .LATENCY(7), .INIT_FILE("")) u_l7 (
    .clk(clk), .rst_n(rst_n), .read(s_read), .write(s_write), .addr(s_addr), .wdata(s_wdata),
    .resp(s_resp[2]), .rdata(s_rdata[2]), .err(s_err[2]), .busy(s_busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request until resp; n is the edge index of resp relative to acceptance.
  task automatic do_txn(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output int n, output logic e, output logic [7:0] r);
    read = rd; write = wr; addr = a; wdata = d;
    n = -1; e = 1'bx; r = 8'hxx;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (resp) begin
        n = k; e = err; r = rdata;
        break;
      end
    end
    read = 1'b0; write = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read = 0; write = 0; addr = 0; wdata = 0;
    s_read = 0; s_write = 0; s_addr = 0; s_wdata = 0;
    #12;
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", resp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_init_read();
    int n; logic e; logic [7:0] r;
    do_txn(1'b0, 1'b1, 8'd3, 8'hA5, n, e, r);
    checks++; if (n !== 3) begin errors++; $display("FAIL write3_latency: got %0d want 3", n); end
    read = 1'b1; addr = 8'd3;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 0) addr = 8'd5;
      checks++;
      if (busy !== (k < 4) || resp !== (k == 3)) begin
        errors++;
        $display("FAIL read3_timing E%0d: busy=%b resp=%b want busy=%b resp=%b", k, busy, resp, k < 4, k == 3);
      end
      if (k == 3) begin
        read = 1'b0;
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL read3_data: got %h want a5", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL read3_err: got %b want 0", err); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1; int t2 = -1; int n; logic e; logic [7:0] r;
    write = 1'b1; read = 1'b0; addr = 8'd5; wdata = 8'h3C;
    for (int k = 0; k <= 30; k++) begin
      tick();
      if (resp && t1 < 0) begin
        t1 = k;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_write_err: got %b want 0", err); end
        write = 1'b0; read = 1'b1;
      end else if (resp) begin
        t2 = k;
        break;
      end
    end
    read = 1'b0;
    checks++; if (t1 !== 3) begin errors++; $display("FAIL b2b_first_resp: got E%0d want E3", t1); end
    checks++; if (t2 - t1 !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", t2 - t1); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL b2b_rdata: got %h want 3c", rdata); end
    tick();
    do_txn(1'b0, 1'b1, 8'd5, 8'h11, n, e, r);
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL write_keeps_rdata: got %h want 3c", rdata); end
    do_txn(1'b1, 1'b0, 8'd5, 8'h00, n, e, r);
    checks++; if (r !== 8'h11) begin errors++; $display("FAIL reread5: got %h want 11", r); end
  endtask

  task automatic test_out_of_range();
    int n; logic e; logic [7:0] r;
    for (int i = 0; i < 8; i++) do_txn(1'b0, 1'b1, 8'(i), 8'(8'h10 + i), n, e, r);
    do_txn(1'b1, 1'b0, 8'd0, 8'h00, n, e, r);
    do_txn(1'b0, 1'b1, 8'd8, 8'hFF, n, e, r);
    checks++; if (n !== 3 || e !== 1'b1) begin errors++; $display("FAIL oor_write: n=%0d err=%b want n=3 err=1", n, e); end
    do_txn(1'b1, 1'b0, 8'd8, 8'h00, n, e, r);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_read_err: got %b want 1", e); end
    checks++; if (r !== 8'h10) begin errors++; $display("FAIL oor_read_rdata: got %h want 10", r); end
    for (int i = 0; i < 8; i++) begin
      do_txn(1'b1, 1'b0, 8'(i), 8'h00, n, e, r);
      checks++;
      if (r !== 8'(8'h10 + i) || e !== 1'b0) begin
        errors++;
        $display("FAIL oor_mem%0d: got %h err=%b want %h err=0", i, r, e, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_illegal();
    int n; logic e; logic [7:0] r;
    do_txn(1'b1, 1'b1, 8'd2, 8'hEE, n, e, r);
    checks++; if (n !== 3 || e !== 1'b1) begin errors++; $display("FAIL illegal_resp: n=%0d err=%b want n=3 err=1", n, e); end
    checks++; if (r !== 8'h17) begin errors++; $display("FAIL illegal_rdata: got %h want 17", r); end
    do_txn(1'b1, 1'b0, 8'd2, 8'h00, n, e, r);
    checks++; if (r !== 8'h12 || e !== 1'b0) begin errors++; $display("FAIL illegal_mem2: got %h err=%b want 12 err=0", r, e); end
  endtask

  task automatic test_reset_mid_write();
    int n; logic e; logic [7:0] r;
    write = 1'b1; addr = 8'd1; wdata = 8'h77;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || resp !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: busy=%b resp=%b want 0 0", busy, resp); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %h want 00", rdata); end
    write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_txn(1'b1, 1'b0, 8'd1, 8'h00, n, e, r);
    checks++; if (n !== 3 || r !== 8'h11) begin errors++; $display("FAIL midrst_readback: n=%0d data=%h want n=3 data=11", n, r); end
  endtask

  task automatic test_latency_sweep();
    int first [3];
    int pulses[3];
    logic bad_err[3];
    int lat  [3] = '{0, 1, 7};
    int want [3] = '{7, 5, 2};
    for (int j = 0; j < 3; j++) begin first[j] = -1; pulses[j] = 0; bad_err[j] = 1'b0; end
    s_write = 1'b1; s_addr = 8'd4; s_wdata = 8'h5A;
    for (int k = 0; k <= 20; k++) begin
      tick();
      for (int j = 0; j < 3; j++) begin
        if (s_resp[j]) begin
          pulses[j]++;
          if (first[j] < 0) first[j] = k;
          if (s_err[j] !== 1'b0) bad_err[j] = 1'b1;
        end
      end
    end
    s_write = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++; if (first[j] !== lat[j] + 1) begin errors++; $display("FAIL sweep_L%0d_first: got E%0d want E%0d", lat[j], first[j], lat[j] + 1); end
      checks++; if (pulses[j] !== want[j]) begin errors++; $display("FAIL sweep_L%0d_pulses: got %0d want %0d", lat[j], pulses[j], want[j]); end
      checks++; if (bad_err[j] !== 1'b0) begin errors++; $display("FAIL sweep_L%0d_err: got 1 want 0", lat[j]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_back_to_back();
    test_out_of_range();
    test_illegal();
    test_reset_mid_write();
    test_latency_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
